// File: rtl/result_buf_arbiter.sv
// Result buffer port arbiter: SPI reads win every cycle, core writes fill free cycles.
// Define RESULT_LOCK_EN to protect an unread result frame from window writes.
module result_buf_arbiter #(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int WIN_BASE = 20,
    parameter int WIN_LAST = 28
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iCLR,
    input  logic          iWr_REQ,
    input  logic [AW-1:0] iWr_ADDR,
    input  logic [DW-1:0] iWr_DATA,
    output logic          oWr_ACK,
    input  logic          iRd_EN,
    input  logic [AW-1:0] iRd_ADDR,
    input  logic          iRd_DONE,
    output logic [DW-1:0] oRd_DATA,
    output logic          oRES_READY,
    output logic          oSESSION,
    output logic          oMEM_CS,
    output logic          oMEM_WE,
    output logic [AW-1:0] oMEM_ADDR,
    output logic [DW-1:0] oMEM_WDATA,
    input  logic [DW-1:0] iMEM_RDATA
);

    localparam logic [AW-1:0] BASE_A = AW'(WIN_BASE);
    localparam logic [AW-1:0] LAST_A = AW'(WIN_LAST);

    typedef enum logic {IDLE, READ} state_t;

    state_t        state;
    logic          active;
    logic          in_window;
    logic          wr_permit;
    logic          frame_set;
    logic          rd_pend;
    logic [DW-1:0] hold_reg;

    // Reset and clear both force the port idle for the cycle they are asserted.
    assign active    = iRSTn && !iCLR;
    assign in_window = (iWr_ADDR >= BASE_A) && (iWr_ADDR <= LAST_A);

`ifdef RESULT_LOCK_EN
    assign wr_permit = !in_window || (!oSESSION && !oRES_READY);
`else
    assign wr_permit = 1'b1;
`endif

    always_comb begin
        oMEM_CS   = 1'b0;
        oMEM_WE   = 1'b0;
        oMEM_ADDR = '0;
        oWr_ACK   = 1'b0;
        if (active) begin
            if (iRd_EN) begin
                oMEM_CS   = 1'b1;
                oMEM_ADDR = iRd_ADDR;
            end else if (iWr_REQ && wr_permit) begin
                oMEM_CS   = 1'b1;
                oMEM_WE   = 1'b1;
                oMEM_ADDR = iWr_ADDR;
                oWr_ACK   = 1'b1;
            end
        end
    end

    assign oMEM_WDATA = iWr_DATA;
    assign oRd_DATA   = rd_pend ? iMEM_RDATA : hold_reg;
    assign frame_set  = oWr_ACK && in_window && (iWr_ADDR == LAST_A);

    always_ff @(posedge iCLK) begin
        if (!active) begin
            state      <= IDLE;
            oSESSION   <= 1'b0;
            oRES_READY <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iRd_EN && !iRd_DONE) begin
                        state    <= READ;
                        oSESSION <= 1'b1;
                    end
                end
                READ: begin
                    if (iRd_DONE) begin
                        state    <= IDLE;
                        oSESSION <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    oSESSION <= 1'b0;
                end
            endcase
            // A frame completing in the same cycle as the host finishing is a new frame.
            if (frame_set)
                oRES_READY <= 1'b1;
            else if (state == READ && iRd_DONE)
                oRES_READY <= 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!active) begin
            rd_pend  <= 1'b0;
            hold_reg <= '0;
        end else begin
            rd_pend <= iRd_EN;
            if (rd_pend)
                hold_reg <= iMEM_RDATA;
        end
    end

endmodule
